// File: rtl/pulse_stretch_tx_pkg.sv
// Shared definitions for the pulse stretcher:
// lane state encoding, counter sizing and legal parameter minimums.
package pulse_stretch_tx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam int MIN_HIGH_CYCLES = 1;
   localparam int MIN_GAP_CYCLES  = 1;

   // Bits needed to hold the larger of the two reload values.
   function automatic int cnt_width(
      input int high_cycles,
      input int gap_cycles
   );
      int m;
      m = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pulse_stretch_lane.sv
// One lane: turns a one-cycle request into a registered high level
// followed by a guaranteed low gap, with one queued request and overflow.
module pulse_stretch_lane
   import pulse_stretch_tx_pkg::*;
#(
   parameter int High_Cycles = 4,
   parameter int Gap_Cycles  = 4
) (
   input  logic clk,
   input  logic ares,
   input  logic req_i,
   output logic out_o,
   output logic busy_o,
   output logic ovf_o
);

   localparam int CW = cnt_width(High_Cycles, Gap_Cycles);
   localparam logic [CW-1:0] HIGH_LOAD = CW'(High_Cycles - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(Gap_Cycles - 1);
   localparam logic [CW-1:0] ONE       = CW'(1);

   if (High_Cycles < MIN_HIGH_CYCLES) begin : g_bad_high
      $error("High_Cycles must be at least 1");
   end
   if (Gap_Cycles < MIN_GAP_CYCLES) begin : g_bad_gap
      $error("Gap_Cycles must be at least 1");
   end

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          ovf_q, ovf_d;
   logic          out_q;
   logic          busy_q;

   // Next state, counter, pending flag and overflow detection.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      ovf_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_i) begin
               state_d = HIGH;
               cnt_d   = HIGH_LOAD;
            end
         end
         HIGH: begin
            if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = GAP_LOAD;
            end else begin
               cnt_d = cnt_q - ONE;
            end
            if (req_i) begin
               if (pend_q) ovf_d  = 1'b1;
               else        pend_d = 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               if (pend_q || req_i) begin
                  // A queued request launches first; a fresh
                  // one arriving now takes its place in the queue.
                  state_d = HIGH;
                  cnt_d   = HIGH_LOAD;
                  pend_d  = pend_q & req_i;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - ONE;
               if (req_i) begin
                  if (pend_q) ovf_d  = 1'b1;
                  else        pend_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
         end
      endcase
   end

   // State and output flops; outputs come straight from registers.
   always_ff @(posedge clk or posedge ares) begin
      if (ares) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         ovf_q   <= 1'b0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         out_q   <= (state_d == HIGH);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign out_o  = out_q;
   assign busy_o = busy_q;
   assign ovf_o  = ovf_q;

endmodule

// File: rtl/pulse_stretch_tx.sv
// Multi-lane pulse stretcher: Width independent lanes side by side.
// No cross-lane logic lives here.
module pulse_stretch_tx
   import pulse_stretch_tx_pkg::*;
#(
   parameter int Width       = 1,
   parameter int High_Cycles = 4,
   parameter int Gap_Cycles  = 4
) (
   input  logic             clk,
   input  logic             ares,
   input  logic [Width-1:0] Sync_Pulse_In,
   output logic [Width-1:0] Async_Out,
   output logic [Width-1:0] Busy,
   output logic [Width-1:0] Overflow
);

   for (genvar i = 0; i < Width; i++) begin : g_lane
      pulse_stretch_lane #(
         .High_Cycles(High_Cycles),
         .Gap_Cycles (Gap_Cycles)
      ) u_lane (
         .clk   (clk),
         .ares  (ares),
         .req_i (Sync_Pulse_In[i]),
         .out_o (Async_Out[i]),
         .busy_o(Busy[i]),
         .ovf_o (Overflow[i])
      );
   end

endmodule

// File: tb/tb_pulse_stretch_tx.sv
// Directed bench for pulse_stretch_tx: vector table, corner sequences
// and an end-to-end run through a 3-flop trailing-edge receiver model.
module tb_pulse_stretch_tx;

   localparam int W = 4;
   localparam int NV = 22;

   logic clk = 1'b0;
   logic rxclk = 1'b0;
   logic ares;
   logic [W-1:0] req;
   logic [W-1:0] aout;
   logic [W-1:0] busy;
   logic [W-1:0] ovf;
   logic req2;
   logic aout2;
   logic busy2;
   logic ovf2;

   int total = 0;
   int bad = 0;

   pulse_stretch_tx #(
      .Width(W), .High_Cycles(4), .Gap_Cycles(4)
   ) dut (
      .clk          (clk),
      .ares         (ares),
      .Sync_Pulse_In(req),
      .Async_Out    (aout),
      .Busy         (busy),
      .Overflow     (ovf)
   );

   pulse_stretch_tx #(
      .Width(1), .High_Cycles(6), .Gap_Cycles(6)
   ) dut2 (
      .clk          (clk),
      .ares         (ares),
      .Sync_Pulse_In(req2),
      .Async_Out    (aout2),
      .Busy         (busy2),
      .Overflow     (ovf2)
   );

   always #5 clk = ~clk;

   always begin
      #8 rxclk = 1'b1;
      #9 rxclk = 1'b0;
   end

   // Receiver model: 3-flop synchroniser, count trailing edges.
   logic [2:0] sync = 3'b000;
   int rx_events = 0;
   always @(posedge rxclk) begin
      sync <= {sync[1:0], aout2};
      if (sync[2] && !sync[1]) rx_events <= rx_events + 1;
   end

   // Transmit-side monitor: events, high run lengths, overflows.
   logic a2_d = 1'b0;
   int hi_len = 0;
   int tx_events = 0;
   int len_err = 0;
   int ovf2_cnt = 0;
   always @(negedge clk) begin
      a2_d   <= aout2;
      hi_len <= aout2 ? hi_len + 1 : 0;
      if (aout2 && !a2_d) tx_events <= tx_events + 1;
      if (a2_d && !aout2 && hi_len != 6) len_err <= len_err + 1;
      if (ovf2) ovf2_cnt <= ovf2_cnt + 1;
   end

   typedef struct {
      logic [W-1:0] req;
      logic [W-1:0] out;
      logic [W-1:0] busy;
      logic [W-1:0] ovf;
   } vec_t;

   vec_t tbl [NV];

   function automatic logic inw(input int t, input int a, input int b);
      return (t >= a) && (t <= b);
   endfunction

   task automatic chk(
      input string name,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic o;
      logic b;
      int k;

      // Lane 0: single event. Lane 1: queued request.
      // Lane 2: queued + dropped request. Lane 3: request in last gap cycle.
      for (int t = 0; t < NV; t++) begin
         tbl[t].req  = {t == 2 || t == 10,
                        t == 2 || t == 4 || t == 5,
                        t == 2 || t == 4,
                        t == 2};
         o = inw(t, 3, 6) || inw(t, 11, 14);
         tbl[t].out  = {o, o, o, inw(t, 3, 6)};
         b = inw(t, 3, 18);
         tbl[t].busy = {b, b, b, inw(t, 3, 10)};
         tbl[t].ovf  = {1'b0, t == 6, 1'b0, 1'b0};
      end

      ares = 1'b1;
      req  = '0;
      req2 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.out", aout, 0);
      chk("reset.busy", busy, 0);
      chk("reset.ovf", ovf, 0);
      ares = 1'b0;

      for (int t = 0; t < NV; t++) begin
         @(posedge clk);
         #1 req = tbl[t].req;
         @(negedge clk);
         chk($sformatf("vec%0d.out", t), aout, tbl[t].out);
         chk($sformatf("vec%0d.busy", t), busy, tbl[t].busy);
         chk($sformatf("vec%0d.ovf", t), ovf, tbl[t].ovf);
      end

      // Pending plus new request in the last gap cycle: no overflow,
      // three back-to-back events on lane 0.
      for (int t = 0; t < 27; t++) begin
         @(posedge clk);
         #1 req = {3'b000, t == 0 || t == 2 || t == 8};
         @(negedge clk);
         o = inw(t, 1, 4) || inw(t, 9, 12) || inw(t, 17, 20);
         b = inw(t, 1, 24);
         chk($sformatf("seqA%0d.out", t), aout, {3'b000, o});
         chk($sformatf("seqA%0d.busy", t), busy, {3'b000, b});
         chk($sformatf("seqA%0d.ovf", t), ovf, 0);
      end

      // Reset mid-HIGH with a request pending on every lane.
      @(posedge clk);
      #1 req = 4'hF;
      @(posedge clk);
      #1 req = 4'h0;
      @(posedge clk);
      #1 req = 4'hF;
      @(posedge clk);
      #1 req = 4'h0;
      @(negedge clk);
      chk("rst.pre_out", aout, 4'hF);
      #2 ares = 1'b1;
      #1;
      chk("rst.async_out", aout, 0);
      chk("rst.async_busy", busy, 0);
      chk("rst.async_ovf", ovf, 0);
      @(posedge clk);
      @(negedge clk);
      ares = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         chk($sformatf("rst.post%0d", t),
             {aout, busy, ovf}, 0);
      end

      // End-to-end through the receiver model.
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1 req2 = 1'b1;
         @(posedge clk);
         #1 req2 = 1'b0;
         repeat ($urandom_range(10, 28)) @(posedge clk);
      end
      k = 0;
      while (busy2 && k < 200) begin
         @(posedge clk);
         k++;
      end
      chk("e2e.drain_timeout", k < 200, 1);
      repeat (10) @(posedge rxclk);
      @(negedge clk);
      chk("e2e.rx_events", rx_events, 50);
      chk("e2e.tx_events", tx_events, 50);
      chk("e2e.high_len_err", len_err, 0);
      chk("e2e.overflows", ovf2_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
